// File: rtl/grad_pkg.sv
// Shared definitions for the 2-D forward-difference gradient engine:
// frame sequencer states and a width-generic saturating subtract.
package grad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StStream,
        StFlush,
        StDone
    } state_e;

    localparam int unsigned MaxWidth = 64;

    // Operands arrive sign-extended to MaxWidth; the result is clipped to the
    // signed range of 'width' bits, so the caller keeps only the low bits.
    function automatic logic signed [MaxWidth-1:0] sat_sub(
        input logic signed [MaxWidth-1:0] a,
        input logic signed [MaxWidth-1:0] b,
        input int unsigned                width
    );
        logic signed [MaxWidth:0] diff;
        logic signed [MaxWidth:0] one;
        logic signed [MaxWidth:0] hi;
        logic signed [MaxWidth:0] lo;
        diff   = {a[MaxWidth-1], a} - {b[MaxWidth-1], b};
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (width - 1)) - one;
        lo     = -(one <<< (width - 1));
        if (diff > hi) begin
            return hi[MaxWidth-1:0];
        end else if (diff < lo) begin
            return lo[MaxWidth-1:0];
        end else begin
            return diff[MaxWidth-1:0];
        end
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row line buffer: simple dual port, read-first, registered read.
// Storage is deliberately not reset.
module line_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             i_clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/grad2d_stream.sv
// Streaming forward-difference gradient (gx, gy) of a raster scalar field with
// Neumann boundary; the last row is replayed from the line buffer in a flush phase.
module grad2d_stream
    import grad_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned COLS   = 64,
    parameter int unsigned ROWS   = 64,
    parameter int unsigned CADDRW = 6,
    parameter int unsigned RADDRW = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data,
    output logic                    o_valid,
    output logic signed [WIDTH-1:0] o_gx,
    output logic signed [WIDTH-1:0] o_gy,
    output logic                    o_busy,
    output logic                    o_done
);

    if (COLS < 2 || ROWS < 2 || WIDTH > MaxWidth) begin : g_bad_size
        $error("grad2d_stream: COLS and ROWS must be >= 2 and WIDTH <= 64");
    end

    localparam logic [CADDRW-1:0] LastCol   = CADDRW'(COLS - 1);
    localparam logic [RADDRW-1:0] LastRow   = RADDRW'(ROWS - 1);
    localparam logic [CADDRW+1:0] FlushRds  = (CADDRW + 2)'(COLS);
    localparam logic [CADDRW+1:0] FlushLast = (CADDRW + 2)'(COLS - 1);
    // Last flush read plus the three-stage emission latency of its trailing sample.
    localparam logic [CADDRW+1:0] FlushEnd  = (CADDRW + 2)'(COLS + 2);

    state_e            state_q;
    logic [CADDRW-1:0] col_q;
    logic [RADDRW-1:0] row_q;
    logic [CADDRW+1:0] fcnt_q;

    logic accept, flush_rd, last_col, last_row;
    logic [CADDRW-1:0] lb_raddr;
    logic [WIDTH-1:0]  lb_rdata;
    logic signed [WIDTH-1:0] lb_rd;

    logic                    s1_valid_q, s1_emit_q, s1_last_q, s1_flush_q;
    logic signed [WIDTH-1:0] s1_data_q, prev_rd_q, prev_data_q;
    logic                    s2_valid_q, s2_tail_q, tail_q;
    logic signed [WIDTH-1:0] s2_gx_q, s2_gy_q, s2_tail_gy_q, tail_gy_q;
    logic signed [WIDTH-1:0] gx_d, gy_d, tail_gy_d;

    assign accept   = i_valid && (state_q == StFill || state_q == StStream);
    assign flush_rd = (state_q == StFlush) && (fcnt_q < FlushRds);
    assign last_col = (col_q == LastCol);
    assign last_row = (row_q == LastRow);
    assign lb_raddr = accept ? col_q : fcnt_q[CADDRW-1:0];
    assign lb_rd    = lb_rdata;

    line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (COLS),
        .AW    (CADDRW)
    ) u_line_buffer (
        .i_clk   (i_clk),
        .we_i    (accept),
        .waddr_i (col_q),
        .wdata_i (i_data),
        .re_i    (accept | flush_rd),
        .raddr_i (lb_raddr),
        .rdata_o (lb_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            fcnt_q  <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StFill;
                        col_q   <= '0;
                        row_q   <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                StFill, StStream: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                            if (state_q == StFill) begin
                                state_q <= StStream;
                            end else if (last_row) begin
                                state_q <= StFlush;
                                fcnt_q  <= '0;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    fcnt_q <= fcnt_q + 1'b1;
                    if (fcnt_q == FlushEnd) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Flush replays row ROWS-1 through the same pipeline with gy forced to zero.
    always_comb begin
        gx_d      = WIDTH'(sat_sub(MaxWidth'(lb_rd), MaxWidth'(prev_rd_q), WIDTH));
        gy_d      = WIDTH'(sat_sub(MaxWidth'(prev_data_q), MaxWidth'(prev_rd_q), WIDTH));
        tail_gy_d = WIDTH'(sat_sub(MaxWidth'(s1_data_q), MaxWidth'(lb_rd), WIDTH));
        if (s1_flush_q) begin
            gy_d      = '0;
            tail_gy_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_emit_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_flush_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tail_q  <= 1'b0;
            tail_q     <= 1'b0;
            o_valid    <= 1'b0;
            o_gx       <= '0;
            o_gy       <= '0;
        end else begin
            s1_valid_q <= accept | flush_rd;
            s1_flush_q <= flush_rd;
            if (accept) begin
                s1_emit_q <= (state_q == StStream) && (col_q != '0);
                s1_last_q <= (state_q == StStream) && last_col;
                s1_data_q <= i_data;
            end else begin
                s1_emit_q <= flush_rd && (fcnt_q != '0);
                s1_last_q <= flush_rd && (fcnt_q == FlushLast);
            end

            s2_valid_q <= s1_valid_q && s1_emit_q;
            s2_tail_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                prev_rd_q    <= lb_rd;
                prev_data_q  <= s1_data_q;
                s2_gx_q      <= gx_d;
                s2_gy_q      <= gy_d;
                s2_tail_gy_q <= tail_gy_d;
            end

            tail_q    <= s2_tail_q;
            tail_gy_q <= s2_tail_gy_q;

            // A c=0 acceptance never emits, so tail and main slots cannot coincide.
            if (tail_q) begin
                o_valid <= 1'b1;
                o_gx    <= '0;
                o_gy    <= tail_gy_q;
            end else if (s2_valid_q) begin
                o_valid <= 1'b1;
                o_gx    <= s2_gx_q;
                o_gy    <= s2_gy_q;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grad2d_stream.sv
// Directed bench for grad2d_stream: a 4x4 instance for frame-level behaviour
// and a default 64x64 instance for spot checks and output count.
module tb_grad2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, valid4, v4, b4, d4;
    logic [31:0] data4, gx4, gy4;
    logic        start64, valid64, v64, b64, d64;
    logic [31:0] data64, gx64o, gy64o;

    grad2d_stream #(
        .WIDTH  (32),
        .COLS   (4),
        .ROWS   (4),
        .CADDRW (2),
        .RADDRW (2)
    ) u_dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start4),
        .i_valid (valid4),
        .i_data  (data4),
        .o_valid (v4),
        .o_gx    (gx4),
        .o_gy    (gy4),
        .o_busy  (b4),
        .o_done  (d4)
    );

    grad2d_stream u_dut64 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start64),
        .i_valid (valid64),
        .i_data  (data64),
        .o_valid (v64),
        .o_gx    (gx64o),
        .o_gy    (gy64o),
        .o_busy  (b64),
        .o_done  (d64)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] img4 [16];
    logic [31:0] gxq [$];
    logic [31:0] gyq [$];
    int          done_cnt4 = 0;
    int          fill_valid = 0;
    bit          in_fill = 1'b0;
    logic        busy_prev4 = 1'b0;
    logic        busy_at_done = 1'bx;
    logic        busy_prev_at_done = 1'bx;

    logic [31:0] gx64 [4096];
    logic [31:0] gy64 [4096];
    int          cnt64 = 0;
    int          done_cnt64 = 0;

    always @(negedge clk) begin
        if (v4) begin
            gxq.push_back(gx4);
            gyq.push_back(gy4);
            if (in_fill) fill_valid++;
        end
        if (d4) begin
            done_cnt4++;
            busy_at_done      = b4;
            busy_prev_at_done = busy_prev4;
        end
        busy_prev4 = b4;
        if (v64) begin
            if (cnt64 < 4096) begin
                gx64[cnt64] = gx64o;
                gy64[cnt64] = gy64o;
            end
            cnt64++;
        end
        if (d64) done_cnt64++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear4();
        gxq.delete();
        gyq.delete();
        done_cnt4 = 0;
        fill_valid = 0;
    endtask

    task automatic set_ramp4();
        for (int k = 0; k < 16; k++) img4[k] = 32'(10 * (k / 4) + (k % 4));
    endtask

    // abort_at < 16 stops feeding before that sample index.
    task automatic feed4(input bit bubbles, input bit poke, input int abort_at);
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4  = 1'b0;
        in_fill = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) break;
            if (bubbles) begin
                while ($urandom_range(0, 99) < 60) begin
                    valid4 = 1'b0;
                    start4 = 1'b0;
                    @(posedge clk); #1;
                end
            end
            valid4 = 1'b1;
            data4  = img4[i];
            start4 = poke && (i == 6);
            @(posedge clk); #1;
            if (i == 3) in_fill = 1'b0;
        end
        valid4 = 1'b0;
        start4 = 1'b0;
        in_fill = 1'b0;
        if (poke && abort_at >= 16) begin
            start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
        end
    endtask

    task automatic wait_done4(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(posedge clk); #1;
            if (done_cnt4 != 0) seen = 1'b1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_ramp4(input string tag);
        check({tag, " count"}, 64'(gxq.size()), 64'd16);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] ogx, ogy;
            ogx = (k < gxq.size()) ? gxq[k] : 32'hxxxx_xxxx;
            ogy = (k < gyq.size()) ? gyq[k] : 32'hxxxx_xxxx;
            check($sformatf("%s gx[%0d]", tag, k), 64'(ogx), ((k % 4) < 3) ? 64'd1 : 64'd0);
            check($sformatf("%s gy[%0d]", tag, k), 64'(ogy), ((k / 4) < 3) ? 64'd10 : 64'd0);
        end
        check({tag, " done_cnt"}, 64'(done_cnt4), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; valid4 = 1'b0; data4 = '0;
        start64 = 1'b0; valid64 = 1'b0; data64 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", 64'(v4), 64'd0);
        check("reset busy", 64'(b4), 64'd0);
        check("reset done", 64'(d4), 64'd0);
        check("reset gx", 64'(gx4), 64'd0);
        check("reset gy", 64'(gy4), 64'd0);
        check("reset valid64", 64'(v64), 64'd0);
        rst = 1'b0;

        // Continuous ramp frame.
        set_ramp4();
        clear4();
        feed4(1'b0, 1'b0, 16);
        wait_done4("cont");
        check_ramp4("cont");
        check("cont busy_at_done", 64'(busy_at_done), 64'd0);
        check("cont busy_before_done", 64'(busy_prev_at_done), 64'd1);

        // Same frame with heavy input bubbles.
        clear4();
        feed4(1'b1, 1'b0, 16);
        wait_done4("bubble");
        check_ramp4("bubble");
        check("bubble fill_valid", 64'(fill_valid), 64'd0);

        // Saturation toward the negative limit.
        for (int k = 0; k < 16; k++) img4[k] = '0;
        img4[0] = 32'h7FFF_FFFF; img4[1] = 32'h8000_0000; img4[4] = 32'h8000_0000;
        clear4();
        feed4(1'b0, 1'b0, 16);
        wait_done4("satA");
        check("satA gx00", 64'(gxq[0]), 64'h8000_0000);
        check("satA gy00", 64'(gyq[0]), 64'h8000_0000);
        check("satA gx01", 64'(gxq[1]), 64'h7FFF_FFFF);
        check("satA gy01", 64'(gyq[1]), 64'h7FFF_FFFF);

        // Swapped values saturate toward the positive limit.
        img4[0] = 32'h8000_0000; img4[1] = 32'h7FFF_FFFF; img4[4] = 32'h7FFF_FFFF;
        clear4();
        feed4(1'b0, 1'b0, 16);
        wait_done4("satB");
        check("satB gx00", 64'(gxq[0]), 64'h7FFF_FFFF);
        check("satB gy00", 64'(gyq[0]), 64'h7FFF_FFFF);
        check("satB gx01", 64'(gxq[1]), 64'h8000_0001);
        check("satB gy10", 64'(gyq[4]), 64'h8000_0001);

        // Reset in the middle of a frame.
        set_ramp4();
        clear4();
        feed4(1'b0, 1'b0, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort valid", 64'(v4), 64'd0);
        check("abort busy", 64'(b4), 64'd0);
        rst = 1'b0;
        begin
            int qs;
            qs = gxq.size();
            repeat (40) @(posedge clk);
            #1;
            check("abort no_more_valid", 64'(gxq.size()), 64'(qs));
            check("abort no_done", 64'(done_cnt4), 64'd0);
        end
        clear4();
        feed4(1'b0, 1'b0, 16);
        wait_done4("after_abort");
        check_ramp4("after_abort");

        // i_start pulses during STREAM and FLUSH must be ignored.
        clear4();
        feed4(1'b0, 1'b1, 16);
        wait_done4("restart");
        check_ramp4("restart");

        // Default 64x64 frame with u = r*c.
        @(posedge clk); #1;
        start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
                valid64 = 1'b1;
                data64  = 32'(r * c);
                @(posedge clk); #1;
            end
        end
        valid64 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 500 && !seen; n++) begin
                @(posedge clk); #1;
                if (done_cnt64 != 0) seen = 1'b1;
            end
            check("big done_seen", 64'(seen), 64'd1);
        end
        repeat (10) @(posedge clk);
        #1;
        check("big count", 64'(cnt64), 64'd4096);
        check("big done_cnt", 64'(done_cnt64), 64'd1);
        check("big gx(5,10)", 64'(gx64[5*64+10]), 64'd5);
        check("big gy(5,10)", 64'(gy64[5*64+10]), 64'd10);
        check("big gx(5,63)", 64'(gx64[5*64+63]), 64'd0);
        check("big gy(63,7)", 64'(gy64[63*64+7]), 64'd0);
        check("big gx(63,7)", 64'(gx64[63*64+7]), 64'd63);
        check("big gy(62,63)", 64'(gy64[62*64+63]), 64'd63);
        check("big gx(0,0)", 64'(gx64[0]), 64'd0);
        check("big gy(0,5)", 64'(gy64[5]), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grad2d_stream.md
Name: grad2d_stream

Overview:
- Forward-difference 2-D gradient engine, the adjoint of the divergence path: it produces (gx, gy) from a scalar field.
- Consumes a raster-order scalar stream (i_valid/i_data, the same format as the divergence block's o_valid/o_data output).
- Emits the gradient stream in raster order, with Neumann boundary: gx = 0 on the last column, gy = 0 on the last row.
- A one-row line buffer holds the previous row; the last row is drained by an internal flush phase.

Parameters:
WIDTH, 32, sample width, signed two's-complement fixed point
COLS, 64, image width in pixels
ROWS, 64, image height in pixels
CADDRW, 6, column counter/line-buffer address width (clog2(COLS))
RADDRW, 6, row counter width (clog2(ROWS))

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous, active-high reset
i_start  input  1  frame start pulse; accepted only in IDLE
i_valid  input  1  input sample qualifier
i_data  input  WIDTH  signed sample u(r,c)
o_valid  output  1  gradient sample qualifier
o_gx  output  WIDTH  signed u(r,c+1)-u(r,c), saturated
o_gy  output  WIDTH  signed u(r+1,c)-u(r,c), saturated
o_busy  output  1  high from accepted i_start until o_done
o_done  output  1  one-cycle pulse after the last output sample

Behaviour:
- Reset (i_reset=1 at a clock edge): state IDLE; counters 0; o_valid/o_busy/o_done = 0; o_gx/o_gy = 0. Line buffer contents are don't-care.
- Reset mid-frame aborts the frame: no further o_valid, no o_done.
- States:
  - IDLE: i_start -> FILL; i_valid ignored.
  - FILL: row 0 accepted; each i_valid writes lb[c]; no outputs. After (0,COLS-1) -> STREAM.
  - STREAM: rows 1..ROWS-1. After (ROWS-1,COLS-1) is accepted and its trailing emission is scheduled -> FLUSH.
  - FLUSH: emits row ROWS-1 from lb at one sample per cycle, no gaps. After the last emission -> DONE; i_valid ignored.
  - DONE: one cycle; o_done=1 -> IDLE.
- i_start in any state other than IDLE is ignored.
- Input may contain bubbles (i_valid=0); counters advance only on accepted samples. There is no output backpressure.
- Line buffer: read-first dual port, 1-cycle registered read. Accepting (r,c) reads the old lb[c] (row r-1) and writes i_data to lb[c] in the same cycle.
- STREAM emission rule, for acceptance of (r,c) at edge t:
  - c>=1: emit (r-1,c-1) with o_valid at t+2. gx = lb[c]-lb[c-1]; gy = u(r,c-1)-lb[c-1]. Previous lb read and previous input are held in registers.
  - c=COLS-1: additionally emit (r-1,COLS-1) at t+3 with gx=0, gy = u(r,COLS-1)-lb[COLS-1].
  - c=0: no emission. This guarantees the t+3 slot never collides, even with back-to-back input.
- FLUSH: reads lb[0..COLS-1] sequentially. Emits (ROWS-1,c) with gx = lb[c+1]-lb[c] (0 at c=COLS-1) and gy=0. The first flush output follows the trailing STREAM emission by ≥1 cycle.
- Arithmetic: difference computed at WIDTH+1 bits, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Exactly ROWS*COLS outputs per frame, strictly raster order.
- o_gx/o_gy hold their last value when o_valid=0.
- Degenerate sizes: COLS>=2 and ROWS>=2 are required. Smaller values are unsupported, and elaboration fails.

Decomposition:
- Package grad_pkg: state encoding (IDLE, FILL, STREAM, FLUSH, DONE) and the sat_sub function (WIDTH-generic saturating subtract).
- Sub-module line_buffer: parameters WIDTH and depth COLS; simple dual-port, read-first, registered read, no reset on storage.
- Everything else (counters, FSM, emission pipeline, flush sequencer) lives in grad2d_stream.

Test Plan:
- COLS=ROWS=4, u(r,c)=10r+c, continuous i_valid:
  - 16 outputs in raster order.
  - gx=1 for c<3, else 0; gy=10 for r<3, else 0.
  - o_done pulses exactly once; o_busy drops in the same cycle.
- Same image with random i_valid bubbles (≥50% idle): identical output values and order; no o_valid during FILL.
- Saturation: u(0,0)=0x7FFFFFFF, u(0,1)=0x80000000 gives gx(0,0)=0x80000000. Swapped values give gx(0,0)=0x7FFFFFFF. gy is checked the same way with u(1,0).
- Reset asserted at input sample 9 of a 4x4 frame:
  - next cycle o_valid=0, o_busy=0, and no o_done follows;
  - a subsequent full frame (u=10r+c) produces correct results.
- i_start pulsed during STREAM and again during FLUSH: ignored. Output count stays 16 and there is one o_done.
- Default 64x64 with u(r,c)=r*c: spot-check gx(5,10)=5, gy(5,10)=10, gx(5,63)=0, gy(63,7)=0. The total o_valid count must be 4096.
